branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch-prediction controller between the fetch and execute stages. It holds a PC-indexed table of 2-bit saturating counters and answers fetch-stage lookups combinationally. It queues each outstanding prediction in order and retires it against the execute-stage outcome, updating the counter. On a misprediction it clears the queue and sequences a one-cycle flush/redirect to the pipeline.

## Interface
- IDX_BITS, 6: counter-table index width; 2^IDX_BITS entries, index = pc[IDX_BITS+1:2]
- QDEPTH, 4: outstanding-prediction queue depth (power of 2, ≥2)
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch slot valid
- if_is_branch  in  1  fetched instruction is a conditional branch
- if_pc  in  32  fetch PC
- if_target  in  32  decoded branch target of fetched instruction
- pred_taken  out  1  prediction for current fetch (comb.)
- pred_next_pc  out  32  next fetch PC (comb.)
- if_stall  out  1  fetch must hold: branch present and queue full (comb.)
- ex_valid  in  1  a branch resolves in EX this cycle
- ex_taken  in  1  actual outcome
- ex_target  in  32  actual target
- flush  out  1  kill all instructions younger than the resolved branch
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  corrected fetch PC
- q_underflow  out  1  sticky: ex_valid arrived with empty queue
- mispredict_count  out  16  wrapping count of mispredictions

## Operation
- Table: 2^IDX_BITS × 2-bit counters, all reset to 2'b00 (strongly not-taken). Taken: +1 saturating at 3. Not taken: −1 saturating at 0. Prediction = counter MSB.
- Lookup (comb.): pred_taken = if_valid & if_is_branch & table[idx(if_pc)][1]. pred_next_pc = pred_taken ? if_target : if_pc+4. pred_taken=0 in RECOVER.
- Queue entry = {idx, predicted bit, pc, target}, FIFO order.
- Push when state=RUN, if_valid, if_is_branch, queue not full, no mispredict this cycle.
- if_stall = if_valid & if_is_branch & full & state=RUN.
- Pop when state=RUN, ex_valid, queue not empty. The head entry is compared:
  - mispredict = (ex_taken ≠ predicted) | (ex_taken & predicted & ex_target ≠ target).
  - Counter at head idx updated with ex_taken every pop, mispredict or not.
- Push and pop in one cycle without mispredict: both occur, occupancy unchanged. Push allowed when full only if a pop occurs the same cycle; if_stall still follows the full flag.
- ex_valid with empty queue in RUN: no table update; q_underflow set until reset.
- Lookup and update of the same index in one cycle: lookup returns the pre-update value; no bypass.
- FSM states:
  - RUN: normal operation. A mispredict pops, updates the counter, clears the whole queue (incoming push discarded), latches redirect_pc = ex_taken ? ex_target : pc+4, increments mispredict_count, then goes to RECOVER.
  - RECOVER, one cycle: flush=1, redirect_valid=1. No push or pop; ex_valid and fetch inputs ignored. Returns to RUN.
- Arithmetic: pc+4 and the counters are modulo 2^32 and 2^16, wrap silently.

## Timing
- Reset: state=RUN, queue empty, table all 00, flush=0, redirect_valid=0, redirect_pc=0, q_underflow=0, mispredict_count=0. Reset is effective mid-RECOVER: flush drops immediately.
- Lookup latency: 0 cycles.
- Counter update visible to lookups in the cycle after the resolving edge.
- Mispredict at cycle T (ex_valid sampled at edge T): flush and redirect_valid high for exactly cycle T+1 (registered), redirect_pc stable in T+1. First new push possible at T+2.
- flush/redirect_valid never high on two consecutive cycles. Back-to-back mispredicts are impossible because RECOVER ignores ex_valid.

## Test plan
- After reset, fetch branch pc=0x100, target=0x200 -> pred_taken=0, pred_next_pc=0x104. Resolve taken -> flush and redirect_valid high one cycle with redirect_pc=0x200, mispredict_count=1.
- Resolve the same pc taken 3 more times. The counter goes 01→10→11: the first of these mispredicts (predicted 0), the next two do not. Next lookup predicts taken, pred_next_pc=0x200, mispredict_count=2.
- Push QDEPTH=4 branches with no resolution -> if_stall=1 on the 5th. Same cycle push+pop at full -> occupancy stays 4, no loss of order.
- 3 queued entries, oldest mispredicts with simultaneous fetch push -> queue empty after edge, push dropped. In RECOVER, ex_valid is ignored and the counter is unchanged.
- Predicted taken to 0x200, resolves taken to 0x300 -> mispredict, redirect_pc=0x300.
- ex_valid on empty queue -> q_underflow=1 and stays set, table unchanged. Assert reset_n low during RECOVER -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch predictor: 2-bit counter table, in-order prediction queue,
// one-cycle flush/redirect sequencing on a resolved misprediction.
module branch_ctrl #(
  parameter int IDX_BITS = 6,
  parameter int QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid,
  input  logic        if_is_branch,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_target,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  output logic        if_stall,
  input  logic        ex_valid,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        q_underflow,
  output logic [15:0] mispredict_count
);

  localparam int TBL = 1 << IDX_BITS;
  localparam int QW  = $clog2(QDEPTH);

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic                pred;
    logic [31:0]         pc;
    logic [31:0]         target;
  } ent_t;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t state, state_nxt;

  logic [1:0]        tbl [TBL];
  ent_t              q   [QDEPTH];
  logic [QW-1:0]     rd, wr;
  logic [QW:0]       cnt;

  logic [IDX_BITS-1:0] if_idx;
  logic                run;
  logic                full, empty;
  logic                push, pop;
  logic                mispredict;
  logic                uflow_set;
  ent_t                head;
  ent_t                incoming;
  logic [1:0]          cur, upd;

  assign run    = (state == RUN);
  assign if_idx = if_pc[IDX_BITS+1:2];
  assign full   = (cnt == (QW+1)'(QDEPTH));
  assign empty  = (cnt == '0);
  assign head   = q[rd];

  assign pred_taken   = run & if_valid & if_is_branch & tbl[if_idx][1];
  assign pred_next_pc = pred_taken ? if_target : if_pc + 32'd4;
  assign if_stall     = run & if_valid & if_is_branch & full;

  assign pop = run & ex_valid & ~empty;

  // Taken-but-wrong-target counts as a mispredict only when taken was predicted.
  assign mispredict = pop &
    ((ex_taken != head.pred) |
     (ex_taken & head.pred & (ex_target != head.target)));

  // A slot freed by a same-cycle pop may be reused even when full.
  assign push = run & if_valid & if_is_branch &
                (~full | pop) & ~mispredict;

  assign uflow_set = run & ex_valid & empty;

  assign incoming.idx    = if_idx;
  assign incoming.pred   = tbl[if_idx][1];
  assign incoming.pc     = if_pc;
  assign incoming.target = if_target;

  assign cur = tbl[head.idx];

  always_comb begin
    upd = cur;
    if (ex_taken) begin
      if (cur != 2'b11) upd = cur + 2'd1;
    end else begin
      if (cur != 2'b00) upd = cur - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (mispredict) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
    endcase
  end

  assign flush          = (state == RECOVER);
  assign redirect_valid = (state == RECOVER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TBL; i++) tbl[i] <= 2'b00;
    end else if (pop) begin
      tbl[head.idx] <= upd;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wr] <= incoming;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (mispredict) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr + QW'(1);
      if (pop)  rd <= rd + QW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (QW+1)'(1);
        2'b01:   cnt <= cnt - (QW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_pc      <= 32'd0;
      mispredict_count <= 16'd0;
    end else if (mispredict) begin
      redirect_pc      <= ex_taken ? ex_target : head.pc + 32'd4;
      mispredict_count <= mispredict_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       q_underflow <= 1'b0;
    else if (uflow_set) q_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vectors, redirect
// events checked by a scoreboard monitor.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid, if_is_branch;
  logic [31:0] if_pc, if_target;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        if_stall;
  logic        ex_valid, ex_taken;
  logic [31:0] ex_target;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        q_underflow;
  logic [15:0] mispredict_count;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t expq[$];
  logic prev_rv = 1'b0;

  branch_ctrl #(.IDX_BITS(6), .QDEPTH(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .if_valid(if_valid),
    .if_is_branch(if_is_branch),
    .if_pc(if_pc),
    .if_target(if_target),
    .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc),
    .if_stall(if_stall),
    .ex_valid(ex_valid),
    .ex_taken(ex_taken),
    .ex_target(ex_target),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .q_underflow(q_underflow),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rv <= 1'b0;
    end else begin
      if (redirect_valid || flush) begin
        exp_t e;
        nvec++;
        if (flush !== redirect_valid || prev_rv) begin
          nerr++;
          $display("FAIL redirect_shape: flush=%b rv=%b prev=%b",
                   flush, redirect_valid, prev_rv);
        end else if (expq.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_redirect: pc=%h count=%0d expected none",
                   redirect_pc, mispredict_count);
        end else begin
          e = expq.pop_front();
          if (redirect_pc !== e.pc || mispredict_count !== e.cnt) begin
            nerr++;
            $display("FAIL redirect: pc=%h count=%0d expected pc=%h count=%0d",
                     redirect_pc, mispredict_count, e.pc, e.cnt);
          end
        end
      end
      prev_rv <= redirect_valid;
    end
  end

  task automatic idle();
    if_valid = 0; if_is_branch = 0; if_pc = 0; if_target = 0;
    ex_valid = 0; ex_taken = 0; ex_target = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] tgt);
    if_valid = 1; if_is_branch = 1; if_pc = pc; if_target = tgt;
  endtask

  task automatic resolve(input logic t, input logic [31:0] tgt);
    ex_valid = 1; ex_taken = t; ex_target = tgt;
  endtask

  task automatic expect_redirect(input logic [31:0] pc,
                                 input logic [15:0] c);
    exp_t e;
    e.pc = pc; e.cnt = c;
    expq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    idle();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_flush", 32'(flush), 0);
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_uflow", 32'(q_underflow), 0);
    chk("rst_mcount", 32'(mispredict_count), 0);
    @(negedge clk);
    reset_n = 1;
    cyc();

    // first branch: predicted not-taken, resolves taken
    fetch(32'h100, 32'h200);
    #1;
    chk("lk0_pred", 32'(pred_taken), 0);
    chk("lk0_next", pred_next_pc, 32'h104);
    chk("lk0_stall", 32'(if_stall), 0);
    cyc();
    idle(); resolve(1, 32'h200); expect_redirect(32'h200, 16'd1);
    cyc();
    idle();
    cyc();

    // counter 01 -> still not-taken, mispredict
    fetch(32'h100, 32'h200);
    #1 chk("lk1_pred", 32'(pred_taken), 0);
    cyc();
    idle(); resolve(1, 32'h200); expect_redirect(32'h200, 16'd2);
    cyc();
    idle();
    cyc();
    // counter 10 -> predicted taken, correct
    for (int i = 0; i < 2; i++) begin
      fetch(32'h100, 32'h200);
      #1;
      chk("lk2_pred", 32'(pred_taken), 1);
      chk("lk2_next", pred_next_pc, 32'h200);
      cyc();
      idle(); resolve(1, 32'h200);
      cyc();
      idle();
    end
    fetch(32'h100, 32'h200);
    #1;
    chk("lk3_pred", 32'(pred_taken), 1);
    chk("lk3_next", pred_next_pc, 32'h200);
    chk("lk3_mcount", 32'(mispredict_count), 2);
    idle();

    // fill queue with idx 4..7 (all not-taken)
    for (int i = 0; i < 4; i++) begin
      fetch(32'h10 + 32'(4*i), 32'h110 + 32'(4*i));
      #1 chk("fill_stall", 32'(if_stall), 0);
      cyc();
    end
    // 5th branch (idx0, counter 11) stalls; push with same-cycle pop
    fetch(32'h100, 32'h200);
    #1;
    chk("full_stall", 32'(if_stall), 1);
    chk("full_pred", 32'(pred_taken), 1);
    resolve(0, 32'h0);
    #1 chk("full_pp_stall", 32'(if_stall), 1);
    cyc();
    idle();
    fetch(32'h30, 32'h130);
    #1 chk("still_full", 32'(if_stall), 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      resolve(0, 32'h0);
      cyc();
      idle();
    end
    fetch(32'h30, 32'h130);
    #1 chk("one_left_stall", 32'(if_stall), 0);
    idle();
    // head is the entry pushed while full: predicted taken, not taken
    resolve(0, 32'h0); expect_redirect(32'h104, 16'd3);
    cyc();
    idle();
    cyc();

    // three queued, oldest mispredicts alongside a fetch push
    for (int i = 0; i < 3; i++) begin
      fetch(32'h40 + 32'(4*i), 32'h140 + 32'(4*i));
      cyc();
    end
    fetch(32'h4C, 32'h14C);
    resolve(1, 32'h90); expect_redirect(32'h90, 16'd4);
    cyc();
    // RECOVER: inputs ignored
    idle();
    fetch(32'h100, 32'h200);
    resolve(1, 32'h90);
    #1;
    chk("rec_pred", 32'(pred_taken), 0);
    chk("rec_next", pred_next_pc, 32'h104);
    chk("rec_stall", 32'(if_stall), 0);
    cyc();
    // queue must be empty: ex_valid underflows
    idle(); resolve(1, 32'h90);
    #1 chk("uflow_pre", 32'(q_underflow), 0);
    cyc();
    idle();
    #1 chk("uflow_set", 32'(q_underflow), 1);
    cyc();
    chk("uflow_sticky", 32'(q_underflow), 1);
    fetch(32'h40, 32'h140);
    #1 chk("idx16_pred", 32'(pred_taken), 0);
    fetch(32'h100, 32'h200);
    #1 chk("idx0_pred", 32'(pred_taken), 1);
    chk("idx0_next", pred_next_pc, 32'h200);
    cyc();

    // predicted taken, resolves taken to another target
    idle(); resolve(1, 32'h300); expect_redirect(32'h300, 16'd5);
    cyc();
    // mid-RECOVER asynchronous reset
    idle();
    #1 reset_n = 0;
    #1;
    chk("arst_flush", 32'(flush), 0);
    chk("arst_rv", 32'(redirect_valid), 0);
    chk("arst_rpc", redirect_pc, 0);
    chk("arst_mcount", 32'(mispredict_count), 0);
    chk("arst_uflow", 32'(q_underflow), 0);
    @(negedge clk);
    reset_n = 1;
    cyc();
    fetch(32'h100, 32'h200);
    #1 chk("arst_table", 32'(pred_taken), 0);
    idle();
    cyc();
    chk("redirects_seen", 32'(expq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
